// File: rtl/dma_io_peripheral_pkg.sv
// Shared types and constants for the DMA I/O-side peripheral.
// State encoding is fixed so it can be traced from older waveform tooling.
package dma_io_peripheral_pkg;

    localparam int unsigned DMA_BYTE_W = 8;

    typedef logic [1:0] periph_state_t;

    localparam periph_state_t P_IDLE = 2'd0;
    localparam periph_state_t P_REQ  = 2'd1;
    localparam periph_state_t P_ACK  = 2'd2;
    localparam periph_state_t P_DONE = 2'd3;

endpackage

// File: rtl/dma_io_peripheral_if.sv
// DMA bus strobes plus the local TX/RX byte-stream handshakes of the peripheral.
interface dma_io_peripheral_if;
    import dma_io_peripheral_pkg::*;

    logic                  DREQ;
    logic                  DACK;
    logic                  IOR_N;
    logic                  IOW_N;
    logic                  EOP_N;
    logic [DMA_BYTE_W-1:0] db_in;
    logic [DMA_BYTE_W-1:0] db_out;
    logic                  db_oe;
    logic                  tx_valid;
    logic [DMA_BYTE_W-1:0] tx_data;
    logic                  tx_ready;
    logic                  rx_valid;
    logic [DMA_BYTE_W-1:0] rx_data;
    logic                  rx_ready;

    modport master (
        input  DREQ, db_out, db_oe, tx_ready, rx_valid, rx_data,
        output DACK, IOR_N, IOW_N, EOP_N, db_in, tx_valid, tx_data, rx_ready
    );

    modport slave (
        output DREQ, db_out, db_oe, tx_ready, rx_valid, rx_data,
        input  DACK, IOR_N, IOW_N, EOP_N, db_in, tx_valid, tx_data, rx_ready
    );

endinterface

// File: rtl/dma_sync_fifo.sv
// Synchronous FIFO with occupancy count; a pop frees a slot for a same-cycle push.
module dma_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign count   = wptr_q - rptr_q;
    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dma_io_peripheral.sv
// 8237A-style I/O responder: raises DREQ, serves IOR_N from the TX FIFO and
// captures IOW_N data into the RX FIFO while DACK is held.
module dma_io_peripheral
    import dma_io_peripheral_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                enable,
    input  logic                dir,
    input  logic                demand,
    dma_io_peripheral_if.slave  bus,
    output logic [15:0]         xfer_cnt,
    output logic                eop_seen,
    output logic                underrun,
    output logic                overrun
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    periph_state_t         state_q, state_d;
    logic                  dreq_q, str_q, str_qq, dack_q, eop_pend_q;
    logic [DMA_BYTE_W-1:0] db_lat_q;

    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [DMA_BYTE_W-1:0] tx_head;
    logic [CW-1:0]         tx_count, rx_count, tx_after, rx_after;
    logic                  strobe, done, eop_hit, more, db_oe;

    assign strobe = dir ? bus.IOW_N : bus.IOR_N;
    // Rising edge seen on the delayed copy; DACK must have been high at that edge.
    assign done    = (state_q == P_ACK) && dack_q && str_q && !str_qq;
    assign eop_hit = eop_pend_q || (bus.DACK && !bus.EOP_N);

    assign tx_push = bus.tx_valid && !tx_full;
    assign tx_pop  = done && !dir && !tx_empty;
    assign rx_pop  = bus.rx_ready && !rx_empty;
    assign rx_push = done && dir && (!rx_full || rx_pop);

    assign tx_after = tx_count + CW'(tx_push) - CW'(tx_pop);
    assign rx_after = rx_count + CW'(rx_push) - CW'(rx_pop);
    assign more     = dir ? (rx_after != CW'(DEPTH)) : (tx_after != '0);

    dma_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DMA_BYTE_W)) u_tx_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (tx_push),
        .push_data (bus.tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    dma_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DMA_BYTE_W)) u_rx_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (rx_push),
        .push_data (db_lat_q),
        .pop       (rx_pop),
        .head      (bus.rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            P_IDLE: if (enable && (dir ? !rx_full : !tx_empty)) state_d = P_REQ;
            P_REQ: begin
                if (!enable)       state_d = P_IDLE;
                else if (bus.DACK) state_d = P_ACK;
            end
            P_ACK: begin
                if (done) begin
                    if (eop_hit)              state_d = P_DONE;
                    else if (!demand || !more) state_d = P_IDLE;
                end else if (!bus.DACK && str_q && strobe) begin
                    state_d = P_REQ;
                end
            end
            P_DONE: if (!enable) state_d = P_IDLE;
            default: state_d = P_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= P_IDLE;
            dreq_q     <= 1'b0;
            str_q      <= 1'b1;
            str_qq     <= 1'b1;
            dack_q     <= 1'b0;
            eop_pend_q <= 1'b0;
            db_lat_q   <= '0;
            xfer_cnt   <= '0;
            eop_seen   <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dreq_q     <= (state_d == P_REQ) || (state_d == P_ACK);
            str_q      <= strobe;
            str_qq     <= str_q;
            dack_q     <= bus.DACK;
            eop_pend_q <= (state_q == P_ACK) && !done && eop_hit;
            if (bus.DACK && !bus.IOW_N) db_lat_q <= bus.db_in;
            if ((state_q == P_IDLE) && (state_d == P_REQ)) xfer_cnt <= '0;
            else if (done)                                 xfer_cnt <= xfer_cnt + 16'd1;
            eop_seen <= (state_d == P_DONE) && (state_q != P_DONE);
            if (done && !dir && tx_empty)           underrun <= 1'b1;
            if (done && dir && rx_full && !rx_pop)  overrun  <= 1'b1;
        end
    end

    assign db_oe        = bus.DACK && !bus.IOR_N && !dir && (state_q == P_ACK);
    assign bus.db_oe    = db_oe;
    // An empty FIFO idles at 00 but answers a live read strobe with FF.
    assign bus.db_out   = tx_empty ? (db_oe ? 8'hFF : 8'h00) : tx_head;
    assign bus.DREQ     = dreq_q;
    assign bus.tx_ready = !tx_full;
    assign bus.rx_valid = !rx_empty;

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Scoreboard bench: stimulus tasks queue expected DB/RX bytes from a queue-based
// model; negedge monitors pop and compare whenever the DUT presents data.
module tb_dma_io_peripheral;
    localparam int unsigned DEPTH = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        enable, dir, demand;
    logic [15:0] xfer_cnt;
    logic        eop_seen, underrun, overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_model[$];
    logic [7:0] rx_model[$];
    logic [7:0] exp_db[$];
    logic       exp_underrun = 1'b0;
    logic       exp_overrun  = 1'b0;
    logic       oe_prev      = 1'b0;

    dma_io_peripheral_if bus ();

    dma_io_peripheral #(.DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .enable   (enable),
        .dir      (dir),
        .demand   (demand),
        .bus      (bus),
        .xfer_cnt (xfer_cnt),
        .eop_seen (eop_seen),
        .underrun (underrun),
        .overrun  (overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_dreq(input logic val, input int bound, input string name);
        int n = 0;
        while (bus.DREQ !== val && n < bound) begin
            cyc(1);
            n++;
        end
        check(name, bus.DREQ, val);
    endtask

    task automatic tx_push(input logic [7:0] b);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        tx_model.push_back(b);
        cyc(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic ior_strobe(input bit eop);
        if (tx_model.size() > 0) exp_db.push_back(tx_model.pop_front());
        else begin
            exp_db.push_back(8'hFF);
            exp_underrun = 1'b1;
        end
        bus.IOR_N = 1'b0;
        bus.EOP_N = !eop;
        cyc(2);
        bus.IOR_N = 1'b1;
        bus.EOP_N = 1'b1;
        cyc(2);
    endtask

    task automatic iow_strobe(input logic [7:0] b);
        if (rx_model.size() < DEPTH) rx_model.push_back(b);
        else exp_overrun = 1'b1;
        bus.db_in = b;
        bus.IOW_N = 1'b0;
        cyc(2);
        bus.IOW_N = 1'b1;
        cyc(2);
    endtask

    task automatic run_tx(input bit dm);
        while (tx_model.size() > 0) begin
            wait_dreq(1'b1, 8, "tx_dreq_rise");
            bus.DACK = 1'b1;
            cyc(2);
            do begin
                ior_strobe(1'b0);
                check("tx_dreq_after", bus.DREQ, 32'(dm && tx_model.size() > 0));
            end while (dm && tx_model.size() > 0);
            bus.DACK = 1'b0;
        end
    endtask

    task automatic run_rx(input int k, input bit dm, input bit seq);
        bit exp_hi = 1'b0;
        for (int i = 0; i < k; i++) begin
            if (!exp_hi) begin
                wait_dreq(1'b1, 8, "rx_dreq_rise");
                bus.DACK = 1'b1;
                cyc(2);
            end
            iow_strobe(seq ? 8'(i) : 8'($urandom));
            exp_hi = dm && (rx_model.size() < DEPTH);
            check("rx_dreq_after", bus.DREQ, 32'(exp_hi));
            if (!exp_hi) bus.DACK = 1'b0;
        end
        check("rx_xfer_cnt", xfer_cnt, dm ? k : 1);
        bus.DACK = 1'b0;
        enable   = 1'b0;
        cyc(2);
    endtask

    task automatic drain_rx(input bit rnd);
        int n = 0;
        while (rx_model.size() > 0 && n < 200) begin
            bus.rx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc(1);
            n++;
        end
        bus.rx_ready = 1'b0;
        check("rx_drained", rx_model.size(), 0);
        check("rx_valid_low", bus.rx_valid, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dreq"}, bus.DREQ, 0);
        check({tag, "_db_oe"}, bus.db_oe, 0);
        check({tag, "_db_out"}, bus.db_out, 8'h00);
        check({tag, "_tx_ready"}, bus.tx_ready, 1);
        check({tag, "_rx_valid"}, bus.rx_valid, 0);
        check({tag, "_xfer_cnt"}, xfer_cnt, 0);
        check({tag, "_eop_seen"}, eop_seen, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    always @(negedge CLK) begin
        if (!RESET && bus.db_oe && !oe_prev) begin
            if (exp_db.size() == 0) check("db_unexpected", bus.db_out, 32'hDEAD);
            else check("db_out", bus.db_out, exp_db.pop_front());
        end
        oe_prev = bus.db_oe;
        if (!RESET && bus.rx_valid && bus.rx_ready) begin
            if (rx_model.size() == 0) check("rx_unexpected", bus.rx_data, 32'hDEAD);
            else check("rx_data", bus.rx_data, rx_model.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; enable = 1'b0; dir = 1'b0; demand = 1'b0;
        bus.DACK = 1'b0; bus.IOR_N = 1'b1; bus.IOW_N = 1'b1; bus.EOP_N = 1'b1;
        bus.db_in = 8'h00; bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.rx_ready = 1'b0;
        cyc(2);
        RESET = 1'b0;
        cyc(1);
        check_reset_vals("rst");

        // TX single mode, two bytes
        tx_push(8'hA5);
        tx_push(8'h3C);
        enable = 1'b1;
        run_tx(1'b0);
        check("tx1_xfer_cnt", xfer_cnt, 1);
        enable = 1'b0;
        cyc(2);

        // RX demand mode, fill to DEPTH with 00..07
        dir = 1'b1; demand = 1'b1; enable = 1'b1;
        run_rx(DEPTH, 1'b1, 1'b1);
        check("rx_full_valid", bus.rx_valid, 1);

        // Overrun: write strobe forced into a full RX FIFO
        demand = 1'b0; dir = 1'b0;
        tx_push(8'h5A);
        enable = 1'b1;
        wait_dreq(1'b1, 8, "ovr_dreq");
        bus.DACK = 1'b1;
        cyc(2);
        dir = 1'b1;
        iow_strobe(8'hEE);
        check("ovr_flag", overrun, 32'(exp_overrun));
        check("ovr_xfer_cnt", xfer_cnt, 1);
        bus.DACK = 1'b0; enable = 1'b0;
        cyc(2);
        drain_rx(1'b0);

        // EOP during the third strobe of a demand burst
        dir = 1'b0; demand = 1'b1;
        for (int i = 0; i < 5; i++) tx_push(8'($urandom));
        enable = 1'b1;
        wait_dreq(1'b1, 8, "eop_dreq");
        bus.DACK = 1'b1;
        cyc(2);
        ior_strobe(1'b0);
        ior_strobe(1'b0);
        check("eop_dreq_mid", bus.DREQ, 1);
        ior_strobe(1'b1);
        check("eop_seen_pulse", eop_seen, 1);
        check("eop_dreq_low", bus.DREQ, 0);
        cyc(1);
        check("eop_seen_end", eop_seen, 0);
        bus.DACK = 1'b0;
        cyc(4);
        check("eop_done_hold", bus.DREQ, 0);
        enable = 1'b0;
        cyc(2);
        enable = 1'b1;
        run_tx(1'b1);
        enable = 1'b0;
        cyc(2);

        // Underrun: read strobe forced with the TX FIFO empty
        dir = 1'b1; demand = 1'b0; enable = 1'b1;
        wait_dreq(1'b1, 8, "udr_dreq");
        bus.DACK = 1'b1;
        cyc(2);
        dir = 1'b0;
        ior_strobe(1'b0);
        check("udr_flag", underrun, 32'(exp_underrun));
        check("udr_xfer_cnt", xfer_cnt, 1);
        bus.DACK = 1'b0; enable = 1'b0;
        cyc(2);

        // DACK withdrawn in P_ACK, bus noise ignored, then normal completion
        tx_push(8'hC3);
        tx_push(8'h96);
        enable = 1'b1;
        wait_dreq(1'b1, 8, "wd_dreq");
        bus.DACK = 1'b1;
        cyc(2);
        bus.DACK = 1'b0;
        cyc(3);
        check("wd_dreq_held", bus.DREQ, 1);
        bus.IOR_N = 1'b0;
        cyc(2);
        bus.IOR_N = 1'b1;
        cyc(3);
        check("wd_noise_xfer", xfer_cnt, 0);
        check("wd_noise_dreq", bus.DREQ, 1);
        bus.DACK = 1'b1;
        cyc(2);
        ior_strobe(1'b0);
        check("wd_xfer_cnt", xfer_cnt, 1);
        check("wd_dreq_drop", bus.DREQ, 0);
        bus.DACK = 1'b0;
        run_tx(1'b0);
        enable = 1'b0;
        cyc(2);

        // Randomized bursts in both directions and modes
        for (int it = 0; it < 8; it++) begin
            automatic int  k  = $urandom_range(1, DEPTH);
            automatic bit  dm = 1'($urandom_range(0, 1));
            demand = dm;
            if ($urandom_range(0, 1) == 0) begin
                dir = 1'b0;
                for (int i = 0; i < k; i++) tx_push(8'($urandom));
                enable = 1'b1;
                run_tx(dm);
                check("rnd_tx_xfer_cnt", xfer_cnt, dm ? k : 1);
                enable = 1'b0;
                cyc(2);
            end else begin
                dir = 1'b1;
                enable = 1'b1;
                run_rx(k, dm, 1'b0);
                drain_rx(1'b1);
            end
        end

        // RESET pulsed while a read strobe is driving DB
        dir = 1'b0; demand = 1'b0;
        tx_push(8'h11);
        tx_push(8'h22);
        enable = 1'b1;
        wait_dreq(1'b1, 8, "rst_mid_dreq");
        bus.DACK = 1'b1;
        cyc(2);
        exp_db.push_back(tx_model.pop_front());
        bus.IOR_N = 1'b0;
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        tx_model.delete();
        exp_underrun = 1'b0;
        exp_overrun  = 1'b0;
        check_reset_vals("rst_mid");
        cyc(1);
        bus.IOR_N = 1'b1;
        bus.DACK  = 1'b0;
        RESET     = 1'b0;
        cyc(3);
        check("rst_fifo_empty_dreq", bus.DREQ, 0);
        check("rst_fifo_empty_ready", bus.tx_ready, 1);
        enable = 1'b0;
        cyc(2);

        check("exp_db_consumed", exp_db.size(), 0);
        check("rx_model_consumed", rx_model.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
